// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding,
// default fill word and the word-index width helper.
package imem_boot_pkg;

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   typedef enum logic [1:0] {
      CLEAR = ST_CLEAR,
      LOAD  = ST_LOAD,
      RUN   = ST_RUN
   } state_t;

   localparam logic [31:0] DEFAULT_FILL_WORD = 32'h0000_0000;

   // Keeps single-entry memories from collapsing the index to zero bits.
   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Load stream and CPU fetch port of the boot-loading instruction memory.
// master = program source / CPU side, slave = the memory block.
interface imem_boot_loader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);

   logic              load_valid;
   logic              load_ready;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_data;
   logic              load_last;
   logic [ADDR_W-1:0] fetch_addr;
   logic [DATA_W-1:0] fetch_data;

   modport master (
      output load_valid, load_addr, load_data, load_last, fetch_addr,
      input  load_ready, fetch_data
   );

   modport slave (
      input  load_valid, load_addr, load_data, load_last, fetch_addr,
      output load_ready, fetch_data
   );

endinterface

// File: rtl/imem_boot_loader_array.sv
// Instruction storage: one synchronous write port and one asynchronous read
// port. Contents are never reset; the loader's clear pass initialises them.
module imem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int IDX_W  = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory with a clear -> load -> run boot sequence; holds the CPU
// in reset until the final load beat has been accepted.
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter int                DEPTH     = 64,
   parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(DEFAULT_FILL_WORD)
) (
   input  logic                         clk,
   input  logic                         rst,
   imem_boot_loader_if.slave            bus,
   input  logic                         reload,
   output logic                         cpu_rst,
   output logic                         load_err,
   output logic [$clog2(DEPTH+1)-1:0]   words_loaded
);

   localparam int IDX_W = idx_w(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   clear_idx_q, clear_idx_d;
   logic [CNT_W-1:0]   words_q, words_d;
   logic               err_q, err_d;
   logic               cpu_rst_q, cpu_rst_d;

   logic               load_legal;
   logic               fetch_in_range;
   logic               accept;
   logic               we;
   logic [IDX_W-1:0]   waddr;
   logic [DATA_W-1:0]  wdata;
   logic [DATA_W-1:0]  rdata;
   logic               unused_fetch_lsb;

   // DEPTH is a power of two, so "index < DEPTH" means every bit above the index is zero.
   assign load_legal     = (bus.load_addr[1:0] == 2'b00) &&
                           (bus.load_addr[ADDR_W-1:IDX_W+2] == '0);
   assign fetch_in_range = (bus.fetch_addr[ADDR_W-1:IDX_W+2] == '0);
   assign accept         = bus.load_valid && (state_q == LOAD);
   assign unused_fetch_lsb = ^bus.fetch_addr[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= CLEAR;
         clear_idx_q <= '0;
         words_q     <= '0;
         err_q       <= 1'b0;
         cpu_rst_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         clear_idx_q <= clear_idx_d;
         words_q     <= words_d;
         err_q       <= err_d;
         cpu_rst_q   <= cpu_rst_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      clear_idx_d = clear_idx_q;
      words_d     = words_q;
      err_d       = err_q;
      unique case (state_q)
         CLEAR: begin
            clear_idx_d = clear_idx_q + 1'b1;
            if (clear_idx_q == IDX_W'(DEPTH - 1)) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (accept) begin
               if (load_legal) begin
                  if (words_q != CNT_W'(DEPTH)) begin
                     words_d = words_q + 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
               if (bus.load_last) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (reload) begin
               state_d     = CLEAR;
               clear_idx_d = '0;
               words_d     = '0;
               err_d       = 1'b0;
            end
         end
         default: state_d = CLEAR;
      endcase
      cpu_rst_d = (state_d != RUN);
   end

   // The single write port is shared: clear pass first, then accepted legal beats.
   always_comb begin
      bus.load_ready = (state_q == LOAD);
      we             = 1'b0;
      waddr          = clear_idx_q;
      wdata          = FILL_WORD;
      if (state_q == CLEAR) begin
         we = 1'b1;
      end else if (state_q == LOAD) begin
         we    = accept && load_legal;
         waddr = bus.load_addr[IDX_W+1:2];
         wdata = bus.load_data;
      end
      bus.fetch_data = (state_q == RUN && fetch_in_range) ? rdata : FILL_WORD;
   end

   imem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (bus.fetch_addr[IDX_W+1:2]),
      .rdata (rdata)
   );

   assign cpu_rst      = cpu_rst_q;
   assign load_err     = err_q;
   assign words_loaded = words_q;

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Parametrised instruction-memory block with a built-in boot loader for the single-cycle MIPS CPU. It replaces the free-running initialize/address/data write port with a valid/ready load stream and a clear-then-load-then-run state machine. It owns the CPU's reset while a program is being loaded. The CPU fetches from it combinationally, and it releases the CPU only after the final load beat.

## Interface
- DATA_W, 32, instruction word width
- ADDR_W, 32, byte-address width of load and fetch addresses
- DEPTH, 64, memory depth in words (power of two, ≥ 2)
- FILL_WORD, 32'h0000_0000, value written during clear and returned for unloaded or out-of-range fetches

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load_valid  in  1  load beat valid
- load_ready  out  1  block accepts a beat this cycle
- load_addr  in  ADDR_W  byte address of the beat
- load_data  in  DATA_W  instruction word
- load_last  in  1  final beat of the program
- reload  in  1  single-cycle request to restart the clear/load sequence
- fetch_addr  in  ADDR_W  CPU PC (byte address)
- fetch_data  out  DATA_W  instruction at fetch_addr (combinational)
- cpu_rst  out  1  reset to the CPU, registered
- load_err  out  1  sticky error flag
- words_loaded  out  clog2(DEPTH+1)  count of accepted, error-free beats

## Operation
- States: CLEAR, LOAD, RUN.
- **CLEAR:**
  - Writes FILL_WORD to word index clear_idx, one word per cycle, with clear_idx running 0..DEPTH-1.
  - Moves to LOAD after index DEPTH-1 is written.
- **LOAD:**
  - load_ready = 1. A beat is accepted when load_valid && load_ready.
  - The beat is legal when load_addr[1:0] == 0 and load_addr[ADDR_W-1:2] < DEPTH.
  - A legal beat writes word index load_addr>>2 and increments words_loaded, which saturates at DEPTH.
  - An illegal beat is consumed but not written, and sets load_err.
  - Duplicate addresses: last write wins, and every write counts.
  - An accepted beat with load_last moves the block to RUN, whether or not the beat was legal.
- **RUN:**
  - load_ready = 0.
  - reload moves the block to CLEAR, resets clear_idx and words_loaded to 0, and clears load_err.
- reload is ignored in CLEAR and LOAD.
- cpu_rst is registered: 1 in CLEAR and LOAD, 0 only in RUN.
- fetch_data:
  - In RUN: mem[fetch_addr>>2] when in range.
  - Out of range, or in any state other than RUN: FILL_WORD.
  - fetch_addr[1:0] is ignored.

## Timing
- **Reset values:**
  - state = CLEAR, clear_idx = 0.
  - load_ready = 0, cpu_rst = 1, load_err = 0, words_loaded = 0, fetch_data = FILL_WORD.
  - Memory contents are not reset asynchronously; CLEAR overwrites them.
- **Clear latency:** after rst deasserts, the first clear write happens at edge 1. load_ready rises after edge DEPTH, in the same cycle the state becomes LOAD.
- **Load acceptance:**
  - The write and counter update happen at the accepting edge.
  - A beat accepted in cycle n is visible via fetch from cycle n+1 once the block is in RUN.
  - Zero-bubble: one beat per cycle is sustainable.
- **Last beat:** the edge that accepts it sets state = RUN and drives cpu_rst to 0. The CPU's first fetch of address 0 occurs in the following cycle.
- **reload:** sampled at an edge in RUN. cpu_rst = 1 from that edge. The new CLEAR takes DEPTH cycles.
- **load_valid during CLEAR or RUN:** no acceptance, no side effects. The source must hold the beat.
- **rst mid-CLEAR or mid-LOAD:** immediate asynchronous return to reset values. Partial contents are discarded by the subsequent CLEAR.

## Structure
- Shared package `imem_boot_pkg`:
  - state encoding localparams (CLEAR = 2'd0, LOAD = 2'd1, RUN = 2'd2)
  - default FILL_WORD
  - a word-index width helper based on clog2(DEPTH)
- Sub-module `imem_array`:
  - DEPTH × DATA_W storage
  - one synchronous write port (we, waddr, wdata)
  - one asynchronous read port
  - the top level muxes the clear and load writes into the single write port.

## Test plan
- **Reset and clear (DEPTH=16):**
  - Deassert rst; drive load_valid = 1 from cycle 0.
  - Required: load_ready = 0 and cpu_rst = 1 for 16 cycles, no beat accepted, then load_ready = 1.
- **Basic load:**
  - Beats (0, 0x0000202A), (4, 0x20220008), (8, 0x08000004, last).
  - Required: cpu_rst falls the cycle after beat 3; fetch 4 returns 0x20220008; fetch 12 returns 0x00000000; words_loaded = 3.
- **Illegal beats:**
  - Beats addr 6 and addr 64 (DEPTH=16), then addr 0 last.
  - Required: load_err = 1, words_loaded = 1, fetch 4 returns FILL_WORD.
- **Back-pressure and gaps:** toggle load_valid every other cycle over 5 beats → exactly 5 writes, contents correct.
- **Reload:**
  - In RUN, pulse reload.
  - Required: cpu_rst = 1 next cycle; all fetches return FILL_WORD; load_err = 0; words_loaded = 0; load_ready returns after 16 cycles.
- **Reset mid-load:**
  - Assert rst between beats 2 and 3.
  - Required: immediate reset values; after the new CLEAR, previously loaded words read FILL_WORD.
